// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int   PS2_DATA_BITS  = 8;
  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by an agreement filter: the output only
// moves after FILTER_LEN consecutive synchronised samples at the new level.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], raw};
    filt_d = filt_q;
    cnt_d  = '0;
    // Any sample agreeing with the current output restarts the run.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{PS2_IDLE_LEVEL}};
      filt_q <= PS2_IDLE_LEVEL;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filtered = filt_q;
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered pins, frame FSM with timeout,
// and a byte FIFO presented as valid/ready.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic             rx_valid,
  output logic [7:0]       rx_data_o,
  output logic [CNT_W-1:0] fifo_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             timeout_err,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS + 1);

  logic clk_f, data_f, clk_prev_q, fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .raw(ps2_clk), .filtered(clk_f));
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .raw(ps2_data), .filtered(data_f));

  assign fall = clk_prev_q & ~clk_f;

  ps2_state_t      state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            to_hit, push;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_err_q, timeout_err_d;

  // A fall in the expiry cycle wins over the timeout.
  assign to_hit = (state_q != IDLE) && !fall &&
                  (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (to_hit) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE:    if (!data_f) state_d = DATA;
        DATA:    if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    to_cnt_d      = '0;
    push          = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q != IDLE && !fall && !to_hit) to_cnt_d = to_cnt_q + TW'(1);
    if (to_hit) begin
      timeout_err_d = 1'b1;
      shift_d       = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_f) bit_cnt_d   = '0;
          else         frame_err_d = 1'b1;
        end
        DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
        PARITY: par_d = data_f;
        default: begin
          if (!data_f)                   frame_err_d  = 1'b1;
          else if (!(^{shift_q, par_q})) parity_err_d = 1'b1;
          else                           push         = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q    <= PS2_IDLE_LEVEL;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      clk_prev_q    <= clk_f;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // FIFO: pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign push_ok = push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = shift_q;
    wr_d  = wr_q + PW'(push_ok);
    rd_d  = rd_q + PW'(pop);
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (err_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  assign rx_valid    = !empty;
  assign rx_data_o   = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign fifo_count  = CNT_W'(wr_q - rd_q);
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: bytes expected in the FIFO are queued
// as frames are sent and popped as the consumer accepts them.
module tb_ps2_rx_fifo;
  localparam int FL = 4;
  localparam int TO = 2048;
  localparam int FD = 8;
  localparam int CW = $clog2(FD + 1);

  logic          clk, rst, ps2_clk, ps2_data, rx_ready, err_clr;
  logic          rx_valid, parity_err, frame_err, timeout_err, overflow;
  logic [7:0]    rx_data_o;
  logic [CW-1:0] fifo_count;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_ready(rx_ready), .err_clr(err_clr), .rx_valid(rx_valid),
    .rx_data_o(rx_data_o), .fifo_count(fifo_count), .parity_err(parity_err),
    .frame_err(frame_err), .timeout_err(timeout_err), .overflow(overflow));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         nchk = 0, nerr = 0;
  int         cyc = 0, pe_cnt = 0, fe_cnt = 0, to_cnt = 0, to_cyc = 0;
  int         exp_pe = 0, exp_fe = 0, exp_to = 0, last_fall = 0;
  logic       exp_ovf = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (parity_err === 1'b1)  pe_cnt <= pe_cnt + 1;
    if (frame_err === 1'b1)   fe_cnt <= fe_cnt + 1;
    if (timeout_err === 1'b1) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (rst === 1'b0 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
      chk("pop_has_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rx_data", rx_data_o, exp_q.pop_front());
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch, input bit pop_at_push);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clk(20);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        wait_clk(6);
        if (pop_at_push) rx_ready = 1'b1;
        wait_clk(1);
        if (pop_at_push) rx_ready = 1'b0;
        if (bad_stop) exp_fe++;
        else if (bad_par) exp_pe++;
        else if (exp_q.size() < FD) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        wait_clk(33);
      end else begin
        wait_clk(40);
      end
      ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(FL - 1);
        ps2_clk = 1'b1;
        wait_clk(20 - 5 - (FL - 1));
      end else begin
        wait_clk(20);
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_parity_err_cnt"}, pe_cnt, exp_pe);
    chk({tag, "_frame_err_cnt"}, fe_cnt, exp_fe);
    chk({tag, "_timeout_err_cnt"}, to_cnt, exp_to);
    chk({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 4 * FD && rx_valid; i++) wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
    chk({tag, "_model_empty"}, exp_q.size(), 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data_empty"}, rx_data_o, 0);
  endtask

  initial begin
    int d;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    wait_clk(2);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_errs", {parity_err, frame_err, timeout_err, overflow}, 0);
    rst = 1'b0;
    wait_clk(1000);
    check_errs("idle");
    chk("idle_rx_valid", rx_valid, 0);

    // Two good frames held, then popped one at a time
    send_frame(8'h1C, 0, 0, 11, 0, 0);
    send_frame(8'hF0, 0, 0, 11, 0, 0);
    chk("two_count", fifo_count, exp_q.size());
    chk("two_head", rx_data_o, 8'h1C);
    wait_clk(10);
    chk("two_head_stable", rx_data_o, 8'h1C);
    rx_ready = 1'b1; wait_clk(1); rx_ready = 1'b0;
    chk("two_second", rx_data_o, 8'hF0);
    rx_ready = 1'b1; wait_clk(1); rx_ready = 1'b0;
    chk("two_drained_valid", rx_valid, 0);
    chk("two_model_empty", exp_q.size(), 0);

    // Error frames and a filtered-out clock glitch
    send_frame(8'h1C, 1, 0, 11, 0, 0);
    wait_clk(5);
    check_errs("bad_par");
    chk("bad_par_count", fifo_count, 0);
    send_frame(8'h3B, 0, 1, 11, 0, 0);
    wait_clk(5);
    check_errs("bad_stop");
    chk("bad_stop_count", fifo_count, 0);
    send_frame(8'hA5, 0, 0, 11, 1, 0);
    chk("glitch_count", fifo_count, 1);
    check_errs("glitch");
    drain("glitch");

    // Timeout after start + 4 data bits
    send_frame(8'h33, 0, 0, 5, 0, 0);
    exp_to++;
    for (int i = 0; i < TO + 200 && to_cnt < exp_to; i++) wait_clk(1);
    wait_clk(2);
    check_errs("timeout");
    d = to_cyc - last_fall;
    chk("timeout_latency_in_window", 32'(d >= TO + FL + 2 && d <= TO + FL + 4), 1);
    send_frame(8'h5A, 0, 0, 11, 0, 0);
    chk("after_to_head", rx_data_o, 8'h5A);
    drain("after_to");

    // Overflow with a stalled consumer
    for (int i = 1; i <= FD + 1; i++) send_frame(8'(i), 0, 0, 11, 0, 0);
    chk("ovf_count", fifo_count, FD);
    chk("ovf_flag", overflow, exp_ovf);
    drain("ovf");
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", overflow, exp_ovf);

    // Continuous draining across pointer wrap
    rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_frame(8'h10 + 8'(i), 0, 0, 11, 0, 0);
    wait_clk(20);
    drain("wrap");
    check_errs("wrap");

    // Full FIFO with a pop coinciding with the push
    for (int i = 0; i <= FD; i++) send_frame(8'h20 + 8'(i), 0, 0, 11, 0, i == FD);
    chk("fullpop_count", fifo_count, FD);
    chk("fullpop_ovf", overflow, exp_ovf);
    chk("fullpop_head", rx_data_o, exp_q[0]);
    drain("fullpop");

    // Reset in the middle of a frame with data buffered
    send_frame(8'h61, 0, 0, 11, 0, 0);
    send_frame(8'h62, 0, 0, 11, 0, 0);
    send_frame(8'h77, 0, 0, 4, 0, 0);
    rst = 1'b1; wait_clk(2); rst = 1'b0;
    exp_q.delete();
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", rx_valid, 0);
    wait_clk(TO + 50);
    check_errs("midrst");
    send_frame(8'h42, 0, 0, 11, 0, 0);
    chk("midrst_next", rx_data_o, 8'h42);
    drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
